// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Wait-state data-memory slave for the load/store path. Accepts one
//            request at a time over valid/ready and returns a one-cycle response.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int         c_depth     = 1 << ADDR_W;
    localparam logic [3:0] c_wait_load = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [c_depth];

    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_error;
    logic        r_busy;

    logic [ADDR_W-1:0] w_index;
    logic              w_error;

    // Decode works on the latched address so late req_* changes cannot leak in.
    assign w_index = r_addr[ADDR_W+1:2];
    assign w_error = (r_addr[1:0] != 2'b00) || (r_addr[31:ADDR_W+2] != '0);

    always_ff @(posedge CLK) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 4'd0;
            r_write     <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_wait_cnt  <= c_wait_load;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (r_wait_cnt != 4'd0) begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                        if (w_error) begin
                            r_rsp_rdata <= 32'd0;
                            r_rsp_error <= 1'b1;
                        end else if (r_write) begin
                            r_mem[w_index] <= r_wdata;
                            r_rsp_rdata    <= 32'd0;
                            r_rsp_error    <= 1'b0;
                        end else begin
                            r_rsp_rdata <= r_mem[w_index];
                            r_rsp_error <= 1'b0;
                        end
                    end
                end

                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_error <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
    assign busy      = r_busy;

endmodule
`default_nettype wire
